// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit with private HI/LO registers.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a single-cycle multiplier.
module ex_muldiv (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic        abort,
   input  logic        hi_wen,
   input  logic        lo_wen,
   input  logic [31:0] wdat,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t      state, next_state;
   logic [1:0]  op_q;
   logic        neg_res, neg_rem, div_zero;
   logic [5:0]  cnt;
   logic [63:0] acc;
   logic [31:0] mcand;
   logic [31:0] rem;

   logic        signed_op;
   logic [31:0] mag_a, mag_b;
   logic [32:0] div_shift, div_trial;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fast_prod;
`else
   logic [32:0] mul_sum;
`endif

   // MULT/DIV (op[0]=0) work on magnitudes; the sign is reapplied in FIX.
   assign signed_op = ~op[0];
   assign mag_a     = (signed_op && opa[31]) ? -opa : opa;
   assign mag_b     = (signed_op && opb[31]) ? -opb : opb;

   // Multiply keeps the multiplier in acc[31:0]; divide shifts the dividend out of
   // acc[31:0] while the quotient shifts in behind it. mcand holds multiplicand/divisor.
`ifdef MULDIV_FAST_MUL_EN
   assign fast_prod = {32'b0, mcand} * {32'b0, acc[31:0]};
`else
   assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'b0);
`endif
   assign div_shift = {rem, acc[31]};
   assign div_trial = div_shift - {1'b0, mcand};

   // Divide-by-zero needs no HI special case: the magnitude remainder equals the
   // dividend magnitude, so restoring the dividend's sign reproduces opa.
   assign prod_fix = neg_res ? -acc : acc;
   assign quo_fix  = div_zero ? 32'hFFFF_FFFF : (neg_res ? -acc[31:0] : acc[31:0]);
   assign rem_fix  = neg_rem ? -rem : rem;

   assign busy = (state != IDLE);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start && !abort) next_state = op[1] ? DIV : MUL;
`ifdef MULDIV_FAST_MUL_EN
         MUL:  next_state = FIX;
`else
         MUL:  if (cnt == 6'd31) next_state = FIX;
`endif
         DIV:  if (cnt == 6'd31) next_state = FIX;
         FIX:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (state != IDLE && abort) next_state = IDLE;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         op_q     <= 2'b00;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         cnt      <= 6'd0;
         acc      <= 64'd0;
         mcand    <= 32'd0;
         rem      <= 32'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_wen) hi <= wdat;
               if (lo_wen) lo <= wdat;
               if (start && !abort) begin
                  op_q     <= op;
                  neg_res  <= signed_op && (opa[31] ^ opb[31]);
                  neg_rem  <= signed_op && opa[31];
                  div_zero <= op[1] && (opb == 32'd0);
                  cnt      <= 6'd0;
                  rem      <= 32'd0;
                  acc      <= {32'd0, op[1] ? mag_a : mag_b};
                  mcand    <= op[1] ? mag_b : mag_a;
               end
            end
            MUL: begin
`ifdef MULDIV_FAST_MUL_EN
               acc <= fast_prod;
`else
               acc <= {mul_sum, acc[31:1]};
`endif
               cnt <= cnt + 6'd1;
            end
            DIV: begin
               rem        <= div_trial[32] ? div_shift[31:0] : div_trial[31:0];
               acc[31:0]  <= {acc[30:0], ~div_trial[32]};
               cnt        <= cnt + 6'd1;
            end
            FIX: begin
               if (!abort) begin
                  if (op_q[1]) begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end else begin
                     hi <= prod_fix[63:32];
                     lo <= prod_fix[31:0];
                  end
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: table of directed mul/div vectors plus
// hand-written sequences for MTHI/MTLO, abort and asynchronous reset.
module tb_ex_muldiv;

   logic        CLK = 1'b0;
   logic        nRST, start, abort, hi_wen, lo_wen;
   logic [1:0]  op;
   logic [31:0] opa, opb, wdat;
   logic        busy, done;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[11];

   always #5 CLK = ~CLK;

   ex_muldiv dut (
      .CLK(CLK), .nRST(nRST), .start(start), .op(op), .opa(opa), .opb(opb),
      .abort(abort), .hi_wen(hi_wen), .lo_wen(lo_wen), .wdat(wdat),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Pulse start for one edge, then count busy cycles until done (bounded).
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output int busy_cycles, output logic finished);
      @(negedge CLK);
      start = 1'b1; op = o; opa = a; opb = b;
      @(negedge CLK);
      start = 1'b0;
      busy_cycles = 0;
      finished = 1'b0;
      for (int i = 0; i < 100 && !finished; i++) begin
         if (busy) busy_cycles++;
         if (done) finished = 1'b1;
         else @(negedge CLK);
      end
   endtask

   function automatic int expLatency(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
      return o[1] ? 33 : 2;
`else
      return 33;
`endif
   endfunction

   initial begin
      int   cyc;
      logic fin;

      vecs[0]  = '{"MULTU ffffffff*ffffffff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1]  = '{"MULT -3*7",               2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2]  = '{"DIV -7/2",                2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{"DIVU 7/0",                2'b11, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
      vecs[4]  = '{"DIV min/-1",              2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5]  = '{"DIV 7/-2",                2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[6]  = '{"MULT min*min",            2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[7]  = '{"DIVU ffffffff/16",        2'b11, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF};
      vecs[8]  = '{"DIV -7/0",                2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[9]  = '{"MULTU x*0",               2'b01, 32'h1234_5678, 32'd0,         32'h0000_0000, 32'h0000_0000};
      vecs[10] = '{"MULT 1*-1",               2'b00, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

      nRST = 1'b0; start = 1'b0; abort = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
      op = 2'b00; opa = 32'd0; opb = 32'd0; wdat = 32'd0;
      #12;
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset done", {31'b0, done}, 32'd0);
      checkOutput("reset hi", hi, 32'd0);
      checkOutput("reset lo", lo, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      for (int v = 0; v < 11; v++) begin
         applyStimulus(vecs[v].op, vecs[v].a, vecs[v].b, cyc, fin);
         checkOutput({vecs[v].name, " done seen"}, {31'b0, fin}, 32'd1);
         checkOutput({vecs[v].name, " busy cycles"}, cyc, expLatency(vecs[v].op));
         checkOutput({vecs[v].name, " hi"}, hi, vecs[v].exp_hi);
         checkOutput({vecs[v].name, " lo"}, lo, vecs[v].exp_lo);
         @(negedge CLK);
         checkOutput({vecs[v].name, " done single"}, {31'b0, done}, 32'd0);
      end

      // MTHI and MTLO on the same edge
      @(negedge CLK);
      hi_wen = 1'b1; lo_wen = 1'b1; wdat = 32'hA5A5_A5A5;
      @(negedge CLK);
      hi_wen = 1'b0; lo_wen = 1'b0;
      checkOutput("dual write hi", hi, 32'hA5A5_A5A5);
      checkOutput("dual write lo", lo, 32'hA5A5_A5A5);

      // abort in IDLE overrides start
      start = 1'b1; op = 2'b01; opa = 32'd3; opb = 32'd4; abort = 1'b1;
      @(negedge CLK);
      start = 1'b0; abort = 1'b0;
      checkOutput("idle abort busy", {31'b0, busy}, 32'd0);

      // preload, then abort a DIVU mid-flight while start/hi_wen are ignored
      hi_wen = 1'b1; wdat = 32'h1111_1111;
      @(negedge CLK);
      hi_wen = 1'b0; lo_wen = 1'b1; wdat = 32'h2222_2222;
      @(negedge CLK);
      lo_wen = 1'b0;
      checkOutput("preload hi", hi, 32'h1111_1111);
      checkOutput("preload lo", lo, 32'h2222_2222);
      start = 1'b1; op = 2'b11; opa = 32'd100; opb = 32'd7;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK);
         if (i == 5) begin hi_wen = 1'b1; wdat = 32'hDEAD_BEEF; end
         if (i == 6) hi_wen = 1'b0;
         if (i == 10) begin abort = 1'b1; start = 1'b0; end
      end
      checkOutput("abort busy before", {31'b0, busy}, 32'd1);
      @(negedge CLK);
      abort = 1'b0;
      checkOutput("abort busy after", {31'b0, busy}, 32'd0);
      checkOutput("abort no done", {31'b0, done}, 32'd0);
      checkOutput("abort hi kept", hi, 32'h1111_1111);
      checkOutput("abort lo kept", lo, 32'h2222_2222);
      @(negedge CLK);
      checkOutput("abort no late done", {31'b0, done}, 32'd0);

      // asynchronous reset in the middle of a MULT
      start = 1'b1; op = 2'b00; opa = 32'd5; opb = 32'd3;
      @(negedge CLK);
      start = 1'b0;
      repeat (19) @(negedge CLK);
      nRST = 1'b0;
      #1;
      checkOutput("async reset busy", {31'b0, busy}, 32'd0);
      checkOutput("async reset done", {31'b0, done}, 32'd0);
      checkOutput("async reset hi", hi, 32'd0);
      checkOutput("async reset lo", lo, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      applyStimulus(2'b01, 32'd6, 32'd7, cyc, fin);
      checkOutput("post reset done seen", {31'b0, fin}, 32'd1);
      checkOutput("post reset hi", hi, 32'd0);
      checkOutput("post reset lo", lo, 32'd42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
